// File: rtl/cpu_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// cpu_timing_pkg
// Shared definitions for the CPU timing generator: FSM state encoding,
// default parameter values and a small width helper.
// -----------------------------------------------------------------------------
package cpu_timing_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUN     = 2'd1;
  localparam state_t ST_STEP    = 2'd2;
  localparam state_t ST_HALTING = 2'd3;

  localparam int DIV_DEF    = 4;
  localparam int PHASES_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_timing_gen_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk into a one-cycle clock-enable pulse every DIV cycles while en is
// high. The count is cleared synchronously whenever en is low, so the first
// tick after enabling always lands DIV cycles later.
//
// Ports:
//   clk   in   system clock
//   reset in   synchronous, active-high
//   en    in   count enable; low holds the count at 0
//   tick  out  en AND count == DIV-1
// -----------------------------------------------------------------------------
module tick_prescaler
  import cpu_timing_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int           W    = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en & w_last;

endmodule

// File: rtl/cpu_timing_gen.sv
// -----------------------------------------------------------------------------
// cpu_timing_gen
// Machine-cycle timing for the CPU model: a prescaled tick enable, a one-hot
// beat ring T0..T(PHASES-1), a run/halt/single-step control FSM and a count of
// completed machine cycles.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   run          in   level; start free-running from IDLE
//   halt         in   level; stop at the end of the current machine cycle
//   step         in   level; from IDLE, execute one machine cycle
//   tick         out  one-clk enable every DIV clks while active
//   phase        out  one-hot beat, bit0 = T0
//   cycle_done   out  tick coincident with the last beat
//   running      out  state is not IDLE
//   cycle_count  out  completed machine cycles, wraps silently
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | stopped at T0, prescaler held at 0
// RUN      | free-running machine cycles until halt
// STEP     | one machine cycle, then back to IDLE
// HALTING  | finishing the current machine cycle before IDLE
// -----------------------------------------------------------------------------
module cpu_timing_gen
  import cpu_timing_pkg::*;
#(
  parameter int DIV    = DIV_DEF,
  parameter int PHASES = PHASES_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              halt,
  input  logic              step,
  output logic              tick,
  output logic [PHASES-1:0] phase,
  output logic              cycle_done,
  output logic              running,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [PHASES-1:0] PHASE_T0 = {{(PHASES-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next_state;
  logic              w_active;
  logic              w_tick;
  logic              w_cycle_done;
  logic [PHASES-1:0] r_phase;
  logic [CNT_W-1:0]  r_cycle_count;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Leaving the active states only happens on cycle_done, so
  // the beat ring is always back at T0 when IDLE is reached. A halt seen in RUN
  // on the same clk as cycle_done still moves to HALTING and therefore runs
  // one more complete machine cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (halt) begin
          w_next_state = ST_IDLE;
        end else if (run) begin
          w_next_state = ST_RUN;
        end else if (step) begin
          w_next_state = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt) begin
          w_next_state = ST_HALTING;
        end
      end
      ST_STEP: begin
        if (w_cycle_done) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_HALTING: begin
        if (w_cycle_done) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (registered state only, no input-to-output path)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_active = (r_state != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (w_active),
    .tick  (w_tick)
  );

  assign w_cycle_done = w_tick & r_phase[PHASES-1];

  // ---------------------------------------------------------------------------
  // Beat ring: rotate left on tick, last beat wraps back to T0
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= PHASE_T0;
    end else if (w_tick) begin
      r_phase <= {r_phase[PHASES-2:0], r_phase[PHASES-1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Completed machine cycles
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if (w_cycle_done) begin
      r_cycle_count <= r_cycle_count + 1'b1;
    end
  end

  assign tick        = w_tick;
  assign phase       = r_phase;
  assign cycle_done  = w_cycle_done;
  assign running     = w_active;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_timing_gen.sv
module tb_cpu_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, halt, step;
  logic        tick, cycle_done, running;
  logic [3:0]  phase;
  logic [15:0] cycle_count;

  logic        run_b, halt_b, step_b;
  logic        tick_b, cycle_done_b, running_b;
  logic [3:0]  phase_b;
  logic [3:0]  cycle_count_b;

  cpu_timing_gen #(.DIV(4), .PHASES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .halt(halt), .step(step),
    .tick(tick), .phase(phase), .cycle_done(cycle_done),
    .running(running), .cycle_count(cycle_count)
  );

  cpu_timing_gen #(.DIV(1), .PHASES(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .run(run_b), .halt(halt_b), .step(step_b),
    .tick(tick_b), .phase(phase_b), .cycle_done(cycle_done_b),
    .running(running_b), .cycle_count(cycle_count_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int t; logic [3:0]  ph;  } tick_e_t;
  typedef struct { int t; logic [15:0] cnt; } done_e_t;

  tick_e_t q_tick_a[$];
  done_e_t q_done_a[$];
  tick_e_t q_tick_b[$];
  done_e_t q_done_b[$];

  // One machine cycle of the DIV=4 instance: ticks every 4 clks from 'first'.
  task automatic push_mcycle_a(input int first, input int cnt);
    tick_e_t e;
    done_e_t d;
    for (int j = 0; j < 4; j++) begin
      e.t  = first + 4 * j;
      e.ph = 4'(1 << j);
      q_tick_a.push_back(e);
    end
    d.t   = first + 12;
    d.cnt = 16'(cnt);
    q_done_a.push_back(d);
  endtask

  task automatic push_tick_a(input int t, input logic [3:0] ph);
    tick_e_t e;
    e.t  = t;
    e.ph = ph;
    q_tick_a.push_back(e);
  endtask

  task automatic until_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard monitor, instance A
  always @(negedge clk) begin : mon_a
    tick_e_t e;
    done_e_t d;
    if (q_tick_a.size() > 0 && q_tick_a[0].t < cyc) begin
      e = q_tick_a.pop_front();
      checks++; failures++;
      $display("FAIL a_tick_missing: no tick at cyc %0d, expected phase %0h", e.t, e.ph);
    end
    if (q_done_a.size() > 0 && q_done_a[0].t < cyc) begin
      d = q_done_a.pop_front();
      checks++; failures++;
      $display("FAIL a_done_missing: no cycle_done at cyc %0d", d.t);
    end
    if (tick) begin
      if (q_tick_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_tick_unexpected: tick at cyc %0d, none expected", cyc);
      end else begin
        e = q_tick_a.pop_front();
        chk("a_tick_time", 32'(cyc), 32'(e.t));
        chk("a_tick_phase", 32'(phase), 32'(e.ph));
      end
    end
    if (cycle_done) begin
      if (q_done_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_done_unexpected: cycle_done at cyc %0d, none expected", cyc);
      end else begin
        d = q_done_a.pop_front();
        chk("a_done_time", 32'(cyc), 32'(d.t));
        chk("a_done_count", 32'(cycle_count), 32'(d.cnt));
      end
    end
  end

  // Scoreboard monitor, instance B
  always @(negedge clk) begin : mon_b
    tick_e_t e;
    done_e_t d;
    if (q_tick_b.size() > 0 && q_tick_b[0].t < cyc) begin
      e = q_tick_b.pop_front();
      checks++; failures++;
      $display("FAIL b_tick_missing: no tick at cyc %0d, expected phase %0h", e.t, e.ph);
    end
    if (q_done_b.size() > 0 && q_done_b[0].t < cyc) begin
      d = q_done_b.pop_front();
      checks++; failures++;
      $display("FAIL b_done_missing: no cycle_done at cyc %0d", d.t);
    end
    if (tick_b) begin
      if (q_tick_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_tick_unexpected: tick at cyc %0d, none expected", cyc);
      end else begin
        e = q_tick_b.pop_front();
        chk("b_tick_time", 32'(cyc), 32'(e.t));
        chk("b_tick_phase", 32'(phase_b), 32'(e.ph));
      end
    end
    if (cycle_done_b) begin
      if (q_done_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_done_unexpected: cycle_done at cyc %0d, none expected", cyc);
      end else begin
        d = q_done_b.pop_front();
        chk("b_done_time", 32'(cyc), 32'(d.t));
        chk("b_done_count", 32'(cycle_count_b), 32'(d.cnt));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    tick_e_t eb;
    done_e_t db;

    reset = 1'b1; run = 1'b0; halt = 1'b0; step = 1'b0;
    run_b = 1'b0; halt_b = 1'b0; step_b = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_phase", 32'(phase), 32'h1);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_count", 32'(cycle_count), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_done", 32'(cycle_done), 32'h0);
    chk("rst_b_phase", 32'(phase_b), 32'h1);
    chk("rst_b_count", 32'(cycle_count_b), 32'h0);

    // Idle for 50 cycles: any tick is flagged by the monitor
    repeat (50) @(negedge clk);
    chk("idle_phase", 32'(phase), 32'h1);
    chk("idle_running", 32'(running), 32'h0);
    chk("idle_count", 32'(cycle_count), 32'h0);

    // Free run, then halt while phase = 0010 in the second machine cycle
    base = cyc;
    run  = 1'b1;
    push_mcycle_a(base + 4, 0);
    push_mcycle_a(base + 20, 1);
    @(negedge clk);
    chk("run_running", 32'(running), 32'h1);
    until_cyc(base + 17);
    chk("run_count1", 32'(cycle_count), 32'h1);
    chk("run_phase_wrap", 32'(phase), 32'h1);
    until_cyc(base + 22);
    chk("halt_phase_at_raise", 32'(phase), 32'h2);
    halt = 1'b1;                       // run kept high: halt wins in IDLE too
    until_cyc(base + 33);
    chk("halt_running", 32'(running), 32'h0);
    chk("halt_phase", 32'(phase), 32'h1);
    chk("halt_count", 32'(cycle_count), 32'h2);
    until_cyc(base + 63);
    chk("run_halt_idle", 32'(running), 32'h0);
    run = 1'b0; halt = 1'b0;

    // Single step with an ignored step/halt/run pulse while in STEP
    base = cyc;
    step = 1'b1;
    push_mcycle_a(base + 4, 2);
    @(negedge clk);
    step = 1'b0;
    until_cyc(base + 8);
    step = 1'b1; halt = 1'b1; run = 1'b1;
    @(negedge clk);
    step = 1'b0; halt = 1'b0; run = 1'b0;
    until_cyc(base + 17);
    chk("step_running", 32'(running), 32'h0);
    chk("step_phase", 32'(phase), 32'h1);
    chk("step_count", 32'(cycle_count), 32'h3);
    until_cyc(base + 37);
    chk("step_stays_idle", 32'(running), 32'h0);

    // Step held across completion: one clk of IDLE, then a second STEP
    base = cyc;
    step = 1'b1;
    push_mcycle_a(base + 4, 3);
    push_mcycle_a(base + 21, 4);
    until_cyc(base + 17);
    chk("step_hold_idle_visit", 32'(running), 32'h0);
    @(negedge clk);
    chk("step_hold_reenter", 32'(running), 32'h1);
    until_cyc(base + 20);
    step = 1'b0;
    until_cyc(base + 34);
    chk("step_hold_running", 32'(running), 32'h0);
    chk("step_hold_count", 32'(cycle_count), 32'h5);

    // Reset mid-cycle at prescaler = 2, phase = 0100
    base = cyc;
    run  = 1'b1;
    push_tick_a(base + 4, 4'b0001);
    push_tick_a(base + 8, 4'b0010);
    until_cyc(base + 11);
    chk("midrst_phase_before", 32'(phase), 32'h4);
    reset = 1'b1; run = 1'b0;
    @(negedge clk);
    chk("midrst_phase", 32'(phase), 32'h1);
    chk("midrst_running", 32'(running), 32'h0);
    chk("midrst_count", 32'(cycle_count), 32'h0);
    chk("midrst_tick", 32'(tick), 32'h0);
    chk("midrst_done", 32'(cycle_done), 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_idle", 32'(running), 32'h0);

    // DIV=1, CNT_W=4: tick every clk, cycle_done every 4, count wraps 15->0->1
    base  = cyc;
    run_b = 1'b1;
    for (int t = 1; t <= 68; t++) begin
      eb.t  = base + t;
      eb.ph = 4'(1 << ((t - 1) % 4));
      q_tick_b.push_back(eb);
    end
    for (int k = 0; k <= 16; k++) begin
      db.t   = base + 4 * k + 4;
      db.cnt = 16'(k % 16);
      q_done_b.push_back(db);
    end
    until_cyc(base + 61);
    chk("b_count15", 32'(cycle_count_b), 32'hF);
    until_cyc(base + 65);
    chk("b_count_wrap0", 32'(cycle_count_b), 32'h0);
    until_cyc(base + 66);
    halt_b = 1'b1;
    until_cyc(base + 69);
    chk("b_halt_running", 32'(running_b), 32'h0);
    chk("b_count_wrap1", 32'(cycle_count_b), 32'h1);
    run_b = 1'b0; halt_b = 1'b0;
    repeat (10) @(negedge clk);

    chk("a_tick_q_empty", 32'(q_tick_a.size()), 32'h0);
    chk("a_done_q_empty", 32'(q_done_a.size()), 32'h0);
    chk("b_tick_q_empty", 32'(q_tick_b.size()), 32'h0);
    chk("b_done_q_empty", 32'(q_done_b.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
